// File: rtl/dtfag_agu_seq_if.sv
// Output bus of the DTFAG address generator.
// Carries MA0..MA3, out_last and the out_valid/out_ready handshake.
interface dtfag_agu_seq_if #(
  parameter int RADIX_W = 4
);
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [RADIX_W-1:0] MA0;
  logic [RADIX_W-1:0] MA1;
  logic [RADIX_W-1:0] MA2;
  logic [RADIX_W-1:0] MA3;

  modport master (
    output out_valid, out_last,
    output MA0, MA1, MA2, MA3,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_last,
    input  MA0, MA1, MA2, MA3,
    output out_ready
  );
endinterface

// File: rtl/dtfag_agu_seq.sv
// Sequenced DTFAG address generator: sweeps (i,t,j) of one stage.
// Ports: clk, rst, start, i/t/j_lim, gray_en, busy, done, bus(master).
module dtfag_agu_seq #(
  parameter int RADIX_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [RADIX_W-1:0] i_lim,
  input  logic [RADIX_W-1:0] t_lim,
  input  logic [RADIX_W-1:0] j_lim,
  input  logic               gray_en,
  output logic               busy,
  output logic               done,
  dtfag_agu_seq_if.master    bus
);

  typedef logic [RADIX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_LAST
  } state_t;

  state_t state, state_n;

  idx_t i_q, t_q, j_q;
  idx_t i_lq, t_lq, j_lq;
  logic gray_q;

  logic valid_q, last_q;
  idx_t ma0_q, ma1_q, ma2_q, ma3_q;

  logic slot, at_end;
  logic accept, load, finish;
  logic j_wrap, t_wrap;
  idx_t i_n, t_n, j_n;
  idx_t t_sel, ma1_n, ma2_n;

  function automatic idx_t gray(idx_t x);
    return x ^ (x >> 1);
  endfunction

  always_comb begin
    slot   = !valid_q || bus.out_ready;
    at_end = (i_q == i_lq) &&
             (t_q == t_lq) &&
             (j_q == j_lq);

    // Odd i walks bank 2 with inverted t
    t_sel = i_q[0] ? ~t_q : t_q;
    ma1_n = gray_q ? gray(i_q) : i_q;
    ma2_n = gray_q ? gray(t_sel) : t_sel;

    j_wrap = (j_q == j_lq);
    t_wrap = (t_q == t_lq);
    j_n = j_wrap ? '0 : j_q + idx_t'(1);
    t_n = t_q;
    i_n = i_q;
    if (j_wrap) begin
      t_n = t_wrap ? '0 : t_q + idx_t'(1);
      if (t_wrap)
        i_n = (i_q == i_lq) ? '0
                            : i_q + idx_t'(1);
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    load    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (slot) begin
          load = 1'b1;
          if (at_end)
            state_n = WAIT_LAST;
        end
      end
      WAIT_LAST: begin
        if (valid_q && bus.out_ready) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      i_q     <= '0;
      t_q     <= '0;
      j_q     <= '0;
      i_lq    <= '0;
      t_lq    <= '0;
      j_lq    <= '0;
      gray_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ma0_q   <= '0;
      ma1_q   <= '0;
      ma2_q   <= '0;
      ma3_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      done  <= finish;
      if (accept) begin
        i_lq   <= i_lim;
        t_lq   <= t_lim;
        j_lq   <= j_lim;
        gray_q <= gray_en;
        i_q    <= '0;
        t_q    <= '0;
        j_q    <= '0;
        busy   <= 1'b1;
      end
      if (load) begin
        ma0_q   <= j_q;
        ma1_q   <= ma1_n;
        ma2_q   <= ma2_n;
        ma3_q   <= j_q;
        last_q  <= at_end;
        valid_q <= 1'b1;
        i_q     <= i_n;
        t_q     <= t_n;
        j_q     <= j_n;
      end
      if (finish) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        busy    <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.MA0       = ma0_q;
  assign bus.MA1       = ma1_q;
  assign bus.MA2       = ma2_q;
  assign bus.MA3       = ma3_q;

endmodule

// File: doc/dtfag_agu_seq.md
Name: dtfag_agu_seq

Overview:
Sequenced, parametrised address generation unit for the DTFAG twiddle-factor ROM banks. It walks the (i, t, j) index space of one FFT stage from internal counters and emits the four bank addresses MA0..MA3 per tuple. MA0/MA3 carry j; MA1 is Gray(i); MA2 is Gray(t) or Gray(~t), selected by i[0]. Output uses a valid/ready handshake with backpressure. Width is generalised via RADIX_W, and a mode input bypasses Gray coding. The block sits between the stage controller and the DTFAG ROM banks.

Parameters:
RADIX_W, 4, index and address width in bits (4 = radix-16)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a sweep when idle
i_lim  input  RADIX_W  last i value (inclusive), sampled on accepted start
t_lim  input  RADIX_W  last t value (inclusive), sampled on accepted start
j_lim  input  RADIX_W  last j value (inclusive), sampled on accepted start
gray_en  input  1  1 = Gray-coded MA1/MA2, 0 = binary; sampled on accepted start
out_ready  input  1  downstream accepts the current tuple
out_valid  output  1  MA0..MA3 and out_last are valid
out_last  output  1  current tuple is the final one of the sweep
MA0  output  RADIX_W  bank-0 address (= j)
MA1  output  RADIX_W  bank-1 address
MA2  output  RADIX_W  bank-2 address
MA3  output  RADIX_W  bank-3 address (= j)
busy  output  1  high while in RUN or WAIT_LAST
done  output  1  one-cycle pulse after the final tuple handshake

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; counters i,t,j=0; out_valid, out_last, busy, done=0; MA0..MA3=0. Reset mid-sweep aborts the sweep. No done is generated. Outputs read the reset values the cycle after.
- Gray function: G(x) = x ^ (x>>1), RADIX_W bits. With gray_en=1: MA1=G(i), MA2 = i[0] ? G(~t) : G(t). With gray_en=0: MA1=i, MA2 = i[0] ? ~t : t. MA0=MA3=j in all cases.
- Counter order: j is innermost, then t, then i. j wraps j_lim→0 and increments t. t wraps t_lim→0 and increments i. A sweep issues (i_lim+1)(t_lim+1)(j_lim+1) tuples.
- States:
  - IDLE: done follows the rule below. On start=1, latch the limits and gray_en, clear the counters, set busy=1, go to RUN. start is ignored in RUN and WAIT_LAST.
  - RUN: a load slot exists when (!out_valid || out_ready). On a load slot, MA* and out_last are registered from the current (i,t,j) and out_valid<=1, then the counters advance. If the loaded tuple is (i_lim,t_lim,j_lim), out_last<=1 and the next state is WAIT_LAST.
  - WAIT_LAST: on out_valid&&out_ready, out_valid<=0, out_last<=0, busy<=0, done<=1 for one cycle, go to IDLE.
- Latency: the first tuple is valid on the 2nd clock edge after the start cycle (registered output, 1 cycle).
- Throughput: 1 tuple per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, MA0..MA3, out_last and the counters hold. No tuple is dropped or duplicated.
- A start asserted in the same cycle that done is high is accepted, because the state is IDLE.
- Limits of 0 are legal; a sweep with all limits 0 issues exactly one tuple with out_last=1.
- Limits of 2^RADIX_W-1 are legal; the counters wrap naturally with no overflow flag.

Test Plan:
- Single tuple: RADIX_W=4, limits 0/0/0, gray_en=1, start, out_ready=1 → 2 edges later out_valid=1, MA0..MA3=0, out_last=1. done pulses once the following cycle, busy then 0.
- Gray/MA2 select: i_lim=3, t_lim=0, j_lim=0, gray_en=1 → MA1 sequence 0,1,3,2; MA2 sequence 0,8,0,8 (G(~0)=8); MA0=MA3=0; 4 tuples, out_last on the 4th.
- Ordering: i_lim=0, t_lim=1, j_lim=2 → MA0 sequence 0,1,2,0,1,2; MA2 sequence 0,0,0,1,1,1; exactly 6 valid handshakes; done 1 cycle after the 6th.
- Binary mode: gray_en=0 with tuple i=1, t=5 reached (i_lim=1, t_lim=5, j_lim=0) → at that tuple MA1=1, MA2=10 (~5).
- Backpressure: a 16-tuple sweep, out_ready held low for 3 cycles at the 5th tuple → outputs stable across the stall, the handshake count is exactly 16, and the value sequence is identical to the unstalled run.
- Reset/start robustness: start pulsed again mid-sweep → ignored, and the tuple count is unchanged. rst asserted mid-sweep → next cycle out_valid=0, busy=0, no done pulse. A fresh start afterwards yields a full correct sweep.
